// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode values and fetch FSM states.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_ALU    = 4'h1;
  localparam logic [3:0] OP_LOAD   = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_BRANCH = 4'h8;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetchState_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational next-PC selection: sequential increment or taken-branch target.
module branch_resolve
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic [3:0]      mm_i,
  input  logic [PC_W-1:0] imm_i,
  input  logic [3:0]      stat_i,
  input  logic            pcSel_i,
  input  logic            brSel_i,
  output logic [PC_W-1:0] nextPc_o
);

  logic            taken;
  logic [PC_W-1:0] target;

  // A zero mask means unconditional; otherwise any masked status flag takes it.
  // PC and offset share a width, so the add wraps and the offset acts as signed.
  assign taken    = (mm_i == 4'h0) || ((mm_i & stat_i) != 4'h0);
  assign target   = brSel_i ? (pc_i + imm_i) : imm_i;
  assign nextPc_o = (pcSel_i && taken) ? target : (pc_i + PC_W'(1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, IR and status registers plus the memory fetch FSM.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_F,
  input  logic               PC_WRITE,
  input  logic               PC_SEL,
  input  logic               BR_SEL,
  input  logic               PC_RST,
  input  logic               STAT_WE,
  input  logic [3:0]         ALU_FLAGS,
  output logic [PC_W-1:0]    IMEM_ADDR,
  output logic               IMEM_REQ,
  input  logic [INSTR_W-1:0] IMEM_RDATA,
  input  logic               IMEM_ACK,
  output logic [INSTR_W-1:0] INSTR,
  output logic [3:0]         OPCODE,
  output logic [3:0]         MM,
  output logic [3:0]         STAT,
  output logic [PC_W-1:0]    PC,
  output logic               FETCH_BUSY
);

  fetchState_t        state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [3:0]         stat_q;
  logic               pend_q;
  logic               pendPcSel_q;
  logic               pendBrSel_q;
  logic               launch_q;
  logic               imemReq_q;
  logic [PC_W-1:0]    imemAddr_q;

  logic               pcSelEff;
  logic               brSelEff;
  logic [PC_W-1:0]    nextPc_d;

  // A pending update uses the selects captured while the fetch was outstanding.
  assign pcSelEff = pend_q ? pendPcSel_q : PC_SEL;
  assign brSelEff = pend_q ? pendBrSel_q : BR_SEL;

  branch_resolve uBranch (
    .pc_i     (pc_q),
    .mm_i     (instr_q[27:24]),
    .imm_i    (instr_q[PC_W-1:0]),
    .stat_i   (stat_q),
    .pcSel_i  (pcSelEff),
    .brSel_i  (brSelEff),
    .nextPc_o (nextPc_d)
  );

  // launch_q resets high so the first edge after reset fetches address 0.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      stat_q      <= '0;
      pend_q      <= 1'b0;
      pendPcSel_q <= 1'b0;
      pendBrSel_q <= 1'b0;
      launch_q    <= 1'b1;
      imemReq_q   <= 1'b0;
      imemAddr_q  <= '0;
    end else begin
      if (STAT_WE) stat_q <= ALU_FLAGS;
      case (state_q)
        IDLE: begin
          if (PC_RST) begin
            pc_q     <= '0;
            pend_q   <= 1'b0;
            launch_q <= 1'b1;
          end else if (pend_q) begin
            pc_q     <= nextPc_d;
            pend_q   <= 1'b0;
            launch_q <= 1'b1;
          end else if (PC_WRITE) begin
            pc_q     <= nextPc_d;
            launch_q <= 1'b1;
          end else if (launch_q) begin
            state_q    <= WAIT;
            imemReq_q  <= 1'b1;
            imemAddr_q <= pc_q;
            launch_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (PC_RST) begin
            pc_q   <= '0;
            pend_q <= 1'b0;
            if (IMEM_ACK) begin
              state_q   <= IDLE;
              imemReq_q <= 1'b0;
              launch_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            if (PC_WRITE && !pend_q) begin
              pend_q      <= 1'b1;
              pendPcSel_q <= PC_SEL;
              pendBrSel_q <= BR_SEL;
            end
            if (IMEM_ACK) begin
              instr_q   <= IMEM_RDATA;
              state_q   <= IDLE;
              imemReq_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Request stays up until the stale read completes; its data is dropped.
          if (PC_RST) begin
            pc_q   <= '0;
            pend_q <= 1'b0;
          end else if (PC_WRITE && !pend_q) begin
            pend_q      <= 1'b1;
            pendPcSel_q <= PC_SEL;
            pendBrSel_q <= BR_SEL;
          end
          if (IMEM_ACK) begin
            state_q   <= IDLE;
            imemReq_q <= 1'b0;
            launch_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          imemReq_q <= 1'b0;
          launch_q  <= 1'b1;
        end
      endcase
    end
  end

  assign IMEM_ADDR  = imemAddr_q;
  assign IMEM_REQ   = imemReq_q;
  assign INSTR      = instr_q;
  assign OPCODE     = instr_q[31:28];
  assign MM         = instr_q[27:24];
  assign STAT       = stat_q;
  assign PC         = pc_q;
  assign FETCH_BUSY = (state_q != IDLE) || pend_q || launch_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable memory.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_F;
  logic        PC_WRITE;
  logic        PC_SEL;
  logic        BR_SEL;
  logic        PC_RST;
  logic        STAT_WE;
  logic [3:0]  ALU_FLAGS;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] INSTR;
  logic [3:0]  OPCODE;
  logic [3:0]  MM;
  logic [3:0]  STAT;
  logic [15:0] PC;
  logic        FETCH_BUSY;

  logic [31:0] mem [64];
  int          ackDelay;
  int          reqCnt = 0;
  int          injectReq = 0;
  int          injectDone = 0;
  int          checks = 0;
  int          errors = 0;

  fetch_unit dut (
    .CLK        (CLK),
    .RST_F      (RST_F),
    .PC_WRITE   (PC_WRITE),
    .PC_SEL     (PC_SEL),
    .BR_SEL     (BR_SEL),
    .PC_RST     (PC_RST),
    .STAT_WE    (STAT_WE),
    .ALU_FLAGS  (ALU_FLAGS),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_RDATA (IMEM_RDATA),
    .IMEM_ACK   (IMEM_ACK),
    .INSTR      (INSTR),
    .OPCODE     (OPCODE),
    .MM         (MM),
    .STAT       (STAT),
    .PC         (PC),
    .FETCH_BUSY (FETCH_BUSY)
  );

  always #5 CLK = ~CLK;

  // Memory acks ackDelay cycles after the request rises; injectReq forces a stray ack.
  always @(posedge CLK) begin
    #2;
    if (IMEM_ACK) begin
      IMEM_ACK = 1'b0;
      reqCnt   = 0;
    end else if (injectReq != injectDone) begin
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = 32'h5A5A_5A5A;
      injectDone = injectReq;
    end else if (IMEM_REQ) begin
      reqCnt++;
      if (reqCnt >= ackDelay) begin
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = mem[IMEM_ADDR[5:0]];
      end
    end else begin
      reqCnt = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic sel, input logic br,
                               input logic rst, input logic we, input logic [3:0] flags);
    PC_WRITE  = w;
    PC_SEL    = sel;
    BR_SEL    = br;
    PC_RST    = rst;
    STAT_WE   = we;
    ALU_FLAGS = flags;
    @(negedge CLK);
    PC_WRITE = 1'b0;
    PC_RST   = 1'b0;
    STAT_WE  = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (FETCH_BUSY !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(tag, 32'(FETCH_BUSY), 32'h0);
  endtask

  initial begin
    RST_F = 1'b0; PC_WRITE = 1'b0; PC_SEL = 1'b0; BR_SEL = 1'b0;
    PC_RST = 1'b0; STAT_WE = 1'b0; ALU_FLAGS = 4'h0; ackDelay = 1;
    for (int i = 0; i < 64; i++) mem[i] = {16'hEE00, 16'(i)};
    mem[0]     = 32'h8100_0005;
    mem[1]     = 32'hDEAD_BEEF;
    mem[2]     = 32'h0BAD_F00D;
    mem[6'h0C] = 32'h0000_FFFF;
    mem[6'h10] = 32'h9200_FFFC;
    mem[6'h11] = 32'h0000_0010;
    mem[63]    = 32'h7000_1234;

    repeat (2) @(negedge CLK);
    checkOutput("rst_pc", 32'(PC), 32'h0);
    checkOutput("rst_instr", INSTR, 32'h0);
    checkOutput("rst_stat", 32'(STAT), 32'h0);
    checkOutput("rst_req", 32'(IMEM_REQ), 32'h0);

    RST_F = 1'b1;
    @(negedge CLK);
    checkOutput("boot_req", 32'(IMEM_REQ), 32'h1);
    checkOutput("boot_addr", 32'(IMEM_ADDR), 32'h0);
    @(negedge CLK);
    checkOutput("boot_instr", INSTR, 32'h8100_0005);
    checkOutput("boot_opcode", 32'(OPCODE), 32'h8);
    checkOutput("boot_mm", 32'(MM), 32'h1);
    checkOutput("boot_pc", 32'(PC), 32'h0);
    checkOutput("boot_busy", 32'(FETCH_BUSY), 32'h0);

    // Refetch address 0 holding an absolute jump to 0x0010.
    mem[0] = 32'h0000_0010;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    waitIdle("pcrst_idle");
    checkOutput("pcrst_instr", INSTR, 32'h0000_0010);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("abs_jump_pc", 32'(PC), 32'h0010);
    checkOutput("abs_jump_busy", 32'(FETCH_BUSY), 32'h1);
    waitIdle("abs_jump_idle");
    checkOutput("abs_jump_instr", INSTR, 32'h9200_FFFC);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1);
    checkOutput("stat_load", 32'(STAT), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("br_not_taken_pc", 32'(PC), 32'h0011);
    waitIdle("br_not_taken_idle");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("back_to_10", 32'(PC), 32'h0010);
    waitIdle("back_to_10_idle");

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("seq_pc", 32'(PC), 32'h0011);
    @(negedge CLK);
    checkOutput("seq_req", 32'(IMEM_REQ), 32'h1);
    checkOutput("seq_addr", 32'(IMEM_ADDR), 32'h0011);
    waitIdle("seq_idle");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    waitIdle("back_again_idle");

    // Relative branch uses STAT=2 although STAT_WE writes 1 on the same edge.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h1);
    checkOutput("br_taken_pc", 32'(PC), 32'h000C);
    checkOutput("br_taken_stat", 32'(STAT), 32'h1);
    waitIdle("br_taken_idle");
    checkOutput("br_taken_instr", INSTR, 32'h0000_FFFF);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("jump_ffff", 32'(PC), 32'hFFFF);
    waitIdle("ffff_idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("pc_wrap", 32'(PC), 32'h0000);
    waitIdle("wrap_idle");
    checkOutput("wrap_instr", INSTR, 32'h0000_0010);

    // PC_RST while a slow fetch at address 1 is outstanding.
    mem[0]   = 32'hA1B2_C3D4;
    ackDelay = 3;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge CLK);
    checkOutput("drain_pre_addr", 32'(IMEM_ADDR), 32'h0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("drain_pc", 32'(PC), 32'h0);
    checkOutput("drain_req", 32'(IMEM_REQ), 32'h1);
    checkOutput("drain_addr", 32'(IMEM_ADDR), 32'h0001);
    repeat (2) @(negedge CLK);
    checkOutput("drain_discard", INSTR, 32'h0000_0010);
    checkOutput("drain_busy", 32'(FETCH_BUSY), 32'h1);
    waitIdle("drain_idle");
    checkOutput("drain_refetch", INSTR, 32'hA1B2_C3D4);
    checkOutput("drain_final_pc", 32'(PC), 32'h0);

    // Two writes during a 4-cycle fetch: only the first is kept as pending.
    ackDelay = 4;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge CLK);
    PC_WRITE = 1'b1; PC_SEL = 1'b0; BR_SEL = 1'b0;
    repeat (2) @(negedge CLK);
    PC_WRITE = 1'b0;
    checkOutput("pend_hold_pc", 32'(PC), 32'h0001);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("pend_busy_%0d", i), 32'(FETCH_BUSY), 32'h1);
      @(negedge CLK);
    end
    waitIdle("pend_idle");
    checkOutput("pend_pc", 32'(PC), 32'h0002);
    checkOutput("pend_instr", INSTR, 32'h0BAD_F00D);

    // Reset mid-fetch, then a stray ack arrives while the FSM sits in IDLE.
    ackDelay = 10;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge CLK);
    checkOutput("midrst_pre_req", 32'(IMEM_REQ), 32'h1);
    #1 RST_F = 1'b0;
    #1;
    checkOutput("midrst_pc", 32'(PC), 32'h0);
    checkOutput("midrst_instr", INSTR, 32'h0);
    checkOutput("midrst_stat", 32'(STAT), 32'h0);
    checkOutput("midrst_req", 32'(IMEM_REQ), 32'h0);
    injectReq++;
    @(negedge CLK);
    RST_F    = 1'b1;
    ackDelay = 1;
    @(negedge CLK);
    checkOutput("late_ack_ignored", INSTR, 32'h0);
    checkOutput("late_ack_req", 32'(IMEM_REQ), 32'h1);
    checkOutput("late_ack_addr", 32'(IMEM_ADDR), 32'h0);
    waitIdle("late_ack_idle");
    checkOutput("late_ack_instr", INSTR, 32'hA1B2_C3D4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 CLK  in  1  clock; all state updates on rising edge.
REQ-002 RST_F  in  1  reset, asynchronous, active-low.
REQ-003 PC_WRITE  in  1  from control FSM; request PC update and refetch.
REQ-004 PC_SEL  in  1  0 = sequential (PC+1), 1 = branch candidate.
REQ-005 BR_SEL  in  1  0 = absolute target, 1 = PC-relative target.
REQ-006 PC_RST  in  1  synchronous PC clear to 0 and refetch.
REQ-007 STAT_WE  in  1  load status register from ALU_FLAGS.
REQ-008 ALU_FLAGS  in  4  ALU condition flags.
REQ-009 IMEM_ADDR  out  16  instruction memory word address.
REQ-010 IMEM_REQ  out  1  memory read request, level.
REQ-011 IMEM_RDATA  in  32  read data, valid when IMEM_ACK=1.
REQ-012 IMEM_ACK  in  1  read complete, one-cycle pulse.
REQ-013 INSTR  out  32  instruction register (IR).
REQ-014 OPCODE  out  4  INSTR[31:28].
REQ-015 MM  out  4  INSTR[27:24].
REQ-016 STAT  out  4  status register.
REQ-017 PC  out  16  program counter.
REQ-018 FETCH_BUSY  out  1  fetch outstanding or update pending.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, DRAIN.
REQ-020 IDLE->WAIT on fetch launch; IMEM_ADDR=PC and IMEM_REQ=1 held stable in WAIT until IMEM_ACK.
REQ-021 WAIT + IMEM_ACK SHALL load INSTR from IMEM_RDATA on that edge and return to IDLE; minimum fetch latency 2 cycles launch-to-IR.
REQ-022 PC_WRITE in IDLE SHALL update PC on that edge and launch a fetch at the new PC next cycle.
REQ-023 Next PC: PC_SEL=0 or branch not taken -> PC+1; taken -> target.
REQ-024 Target: BR_SEL=0 -> INSTR[15:0]; BR_SEL=1 -> PC + sign-extended INSTR[15:0]; all PC arithmetic modulo 2^16 (0xFFFF+1=0x0000).
REQ-025 Taken when MM==0 (unconditional) or (MM & STAT)!=0; evaluated with STAT value before any same-edge STAT_WE write.
REQ-026 PC_WRITE during WAIT or DRAIN SHALL set a one-deep pending flag capturing PC_SEL/BR_SEL; applied on IDLE entry; a second PC_WRITE while pending SHALL be dropped.
REQ-027 PC_RST SHALL set PC=0, clear pending, and launch a fetch at 0; PC_RST wins over simultaneous PC_WRITE.
REQ-028 PC_RST during WAIT SHALL move to DRAIN: keep IMEM_REQ high until ACK, discard that data, then refetch at 0.
REQ-029 STAT_WE SHALL load STAT from ALU_FLAGS on the edge, independent of FSM state.
REQ-030 FETCH_BUSY=1 whenever state!=IDLE or pending flag set or launch scheduled.
REQ-031 INSTR SHALL change only on a non-discarded IMEM_ACK.

Reset
REQ-032 RST_F low SHALL immediately force PC=0, INSTR=0 (OPCODE=noop), STAT=0, pending=0, IMEM_REQ=0, state IDLE.
REQ-033 First rising edge after RST_F release SHALL launch fetch at address 0.
REQ-034 Reset mid-WAIT SHALL abandon the request; a late IMEM_ACK in IDLE SHALL be ignored.

Structure
REQ-035 Shared package cpu_pkg SHALL hold PC width (16), instruction width (32), opcode constants, and fetch state enum.
REQ-036 Next-PC and branch-condition logic SHALL be a combinational sub-module branch_resolve.

Verification
REQ-037 Reset release, memory acks after 1 cycle with 0x8100_0005 -> IMEM_ADDR=0, INSTR=0x81000005, OPCODE=8, MM=1, PC=0.
REQ-038 PC=0x0010, PC_WRITE, PC_SEL=0 -> PC=0x0011, fetch issued at 0x0011.
REQ-039 PC=0x0010, INSTR[15:0]=0xFFFC, BR_SEL=1, MM=2, STAT=2, PC_SEL=1 -> PC=0x000C; same with STAT=1 -> PC=0x0011.
REQ-040 PC=0xFFFF, PC_WRITE sequential -> PC=0x0000.
REQ-041 PC_RST in WAIT with ACK delayed 3 cycles -> stale data discarded, INSTR unchanged until fetch at 0 completes.
REQ-042 PC_WRITE during 4-cycle WAIT -> pending applied after ACK, FETCH_BUSY high throughout, single PC increment.
